// File: rtl/redmule_pkg.sv
// Shared definitions for the RedMulE TCDM splitter: request FSM state
// encoding and lane geometry helpers (lane width, lane byte count, lane
// byte offset from the wide address).
package redmule_pkg;

    typedef logic [0:0] split_state_t;

    localparam split_state_t SPLIT_IDLE  = 1'b0;
    localparam split_state_t SPLIT_ISSUE = 1'b1;

    // Data bits carried by one narrow lane.
    function automatic int unsigned lane_width(input int unsigned dw, input int unsigned mp);
        return dw / mp;
    endfunction

    // Bytes carried by one narrow lane.
    function automatic int unsigned lane_bytes(input int unsigned dw, input int unsigned mp);
        return dw / (mp * 8);
    endfunction

    // Byte offset of a lane relative to the wide request address.
    function automatic int unsigned lane_offset(input int unsigned dw, input int unsigned mp,
                                                input int unsigned lane);
        return lane * lane_bytes(dw, mp);
    endfunction

endpackage

// File: rtl/redmule_tcdm_lane_fifo.sv
// Per-lane response FIFO. Holds narrow read responses until every lane
// has one available; a push while full is dropped.
module redmule_tcdm_lane_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Wrap-around pointer increment for a non-power-of-two depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Status flags and qualified push/pop.
    always_comb begin
        full_o    = (cnt_r == CW'(DEPTH));
        empty_o   = (cnt_r == {CW{1'b0}});
        push_ok_s = push_i && !full_o;
        pop_ok_s  = pop_i && !empty_o;
        head_o    = mem_r[rd_ptr_r];
    end

    // Storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            else           wr_ptr_r <= wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            else           rd_ptr_r <= rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    redmule_tcdm_lane_fifo_chk i_chk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_i),
        .full_i (full_o)
    );

endmodule

// File: rtl/redmule_tcdm_lane_fifo_chk.sv
// Protocol checker for one lane response FIFO: a response arriving while
// the FIFO is full is a memory-side protocol error.
module redmule_tcdm_lane_fifo_chk (
    input logic clk_i,
    input logic rst_i,
    input logic push_i,
    input logic full_i
);

    // Flag a push into a full FIFO.
    push_into_full_a : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i))
        else $error("lane fifo: response pushed into full fifo, dropped");

endmodule

// File: rtl/redmule_tcdm_split.sv
// Splits one wide TCDM request into MP narrow lane requests and merges the
// lane responses back into one wide response. Lanes may grant in different
// cycles; the wide grant pulses once the last lane has granted. At most
// DEPTH wide transactions are outstanding.
// Optional build macro REDMULE_TCDM_SPLIT_RESP_REG_EN registers the wide
// response outputs (response latency 2 instead of 1).
module redmule_tcdm_split
    import redmule_pkg::*;
#(
    parameter int unsigned DW    = 256,
    parameter int unsigned MP    = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    output logic                           gnt_o,
    input  logic [AW-1:0]                  add_i,
    input  logic                           wen_i,
    input  logic [DW/8-1:0]                be_i,
    input  logic [DW-1:0]                  data_i,
    output logic [DW-1:0]                  r_data_o,
    output logic                           r_valid_o,
    output logic [MP-1:0]                  tcdm_req_o,
    input  logic [MP-1:0]                  tcdm_gnt_i,
    output logic [MP-1:0][AW-1:0]          tcdm_add_o,
    output logic [MP-1:0]                  tcdm_wen_o,
    output logic [MP-1:0][DW/(MP*8)-1:0]   tcdm_be_o,
    output logic [MP-1:0][DW/MP-1:0]       tcdm_data_o,
    input  logic [MP-1:0][DW/MP-1:0]       tcdm_r_data_i,
    input  logic [MP-1:0]                  tcdm_r_valid_i
);

    localparam int unsigned LW = lane_width(DW, MP);
    localparam int unsigned LB = lane_bytes(DW, MP);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    split_state_t         state_r;
    logic [MP-1:0]        mask_r;
    logic [CW-1:0]        outst_r;
    logic [MP-1:0]        lane_req_s;
    logic [MP-1:0]        granted_s;
    logic                 wide_gnt_s;
    logic                 pop_s;
    logic [MP-1:0]        fifo_empty_s;
    logic [MP-1:0]        fifo_full_s;
    logic [MP-1:0][LW-1:0] head_s;

    // Lane request generation and wide grant detection.
    always_comb begin
        lane_req_s = {MP{1'b0}};
        if (rst_i) begin
            lane_req_s = {MP{1'b0}};
        end else begin
            case (state_r)
                SPLIT_IDLE: begin
                    if (req_i && (outst_r < CW'(DEPTH))) lane_req_s = {MP{1'b1}};
                    else                                 lane_req_s = {MP{1'b0}};
                end
                SPLIT_ISSUE: lane_req_s = ~mask_r;
                default:     lane_req_s = {MP{1'b0}};
            endcase
        end
        granted_s  = mask_r | (lane_req_s & tcdm_gnt_i);
        wide_gnt_s = (|lane_req_s) && (&granted_s);
    end

    // Lane payload: address offset per lane, byte-enable/data slices.
    always_comb begin
        for (int unsigned i = 0; i < MP; i++) begin
            tcdm_add_o[i]  = add_i + AW'(lane_offset(DW, MP, i));
            tcdm_be_o[i]   = be_i[i*LB +: LB];
            tcdm_data_o[i] = data_i[i*LW +: LW];
        end
        tcdm_wen_o = {MP{wen_i}};
        tcdm_req_o = lane_req_s;
        gnt_o      = wide_gnt_s;
    end

    // Request FSM: track which lanes have granted for the current request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= SPLIT_IDLE;
            mask_r  <= {MP{1'b0}};
        end else if (wide_gnt_s) begin
            state_r <= SPLIT_IDLE;
            mask_r  <= {MP{1'b0}};
        end else if (|lane_req_s) begin
            state_r <= SPLIT_ISSUE;
            mask_r  <= granted_s;
        end else begin
            state_r <= state_r;
            mask_r  <= mask_r;
        end
    end

    // Outstanding wide transaction counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_r <= {CW{1'b0}};
        end else begin
            case ({wide_gnt_s, pop_s})
                2'b10:   outst_r <= outst_r + CW'(1'b1);
                2'b01:   outst_r <= outst_r - CW'(1'b1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    for (genvar g = 0; g < MP; g++) begin : g_lane
        redmule_tcdm_lane_fifo #(
            .WIDTH (LW),
            .DEPTH (DEPTH)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (tcdm_r_valid_i[g]),
            .data_i  (tcdm_r_data_i[g]),
            .pop_i   (pop_s),
            .head_o  (head_s[g]),
            .empty_o (fifo_empty_s[g]),
            .full_o  (fifo_full_s[g])
        );
    end

    // Merge: all lane heads leave together once every lane has one.
    always_comb begin
        pop_s = !rst_i && (&(~fifo_empty_s));
    end

`ifdef REDMULE_TCDM_SPLIT_RESP_REG_EN
    logic          r_valid_r;
    logic [DW-1:0] r_data_r;

    // Registered wide response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_r <= 1'b0;
            r_data_r  <= {DW{1'b0}};
        end else if (pop_s) begin
            r_valid_r <= 1'b1;
            r_data_r  <= head_s;
        end else begin
            r_valid_r <= 1'b0;
            r_data_r  <= {DW{1'b0}};
        end
    end

    // Drive outputs from the response register.
    always_comb begin
        r_valid_o = r_valid_r;
        r_data_o  = r_data_r;
    end
`else
    // Drive outputs straight from the FIFO heads.
    always_comb begin
        r_valid_o = pop_s;
        if (pop_s) r_data_o = head_s;
        else       r_data_o = {DW{1'b0}};
    end
`endif

endmodule

// File: doc/redmule_tcdm_split.md
REDMULE_TCDM_SPLIT -- requirements
Module: redmule_tcdm_split

Interface
REQ-001 SHALL have parameter DW, default 256: wide-side data width in bits.
REQ-002 SHALL have parameter MP, default 4: number of narrow lanes; DW % (MP*32) == 0.
REQ-003 SHALL have parameter AW, default 32: address width.
REQ-004 SHALL have parameter DEPTH, default 2: maximum outstanding wide transactions, >= 1.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i, input, 1 bit: clock, all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have wide slave ports: req_i, gnt_o (1); add_i (AW); wen_i (1); be_i (DW/8); data_i (DW); r_data_o (DW); r_valid_o (1).
REQ-009 SHALL have narrow master ports, per lane: tcdm_req_o, tcdm_gnt_i (MP); tcdm_add_o (MP x AW); tcdm_wen_o (MP); tcdm_be_o (MP x DW/(MP*8)); tcdm_data_o (MP x DW/MP); tcdm_r_data_i (MP x DW/MP); tcdm_r_valid_i (MP).

Function
REQ-010 Lane i SHALL carry add_i + i*DW/(MP*8) and slice i of be_i and data_i; wen_i is copied to every lane.
REQ-011 Request FSM SHALL have states IDLE and ISSUE; a granted-lane mask records lanes already granted for the current wide request.
REQ-012 In IDLE with req_i=1 and outstanding < DEPTH, all lanes SHALL assert tcdm_req_o; otherwise none.
REQ-013 In ISSUE, tcdm_req_o[i] SHALL be asserted only for lanes not in the mask; a lane SHALL never be requested twice per wide request.
REQ-014 gnt_o SHALL pulse for exactly one cycle, in the cycle the last ungranted lane sees tcdm_gnt_i; the FSM then returns to IDLE and clears the mask.
REQ-015 If all lanes grant in the first cycle, gnt_o SHALL assert that cycle without entering ISSUE; partial grant moves IDLE->ISSUE.
REQ-016 The master SHALL hold req_i and payload stable from assertion until gnt_o; the block does not register the payload.
REQ-017 Each lane SHALL own a DEPTH-entry FIFO pushed on tcdm_r_valid_i[i] with tcdm_r_data_i[i].
REQ-018 r_valid_o SHALL assert when all lane FIFOs are non-empty, all heads popped that cycle; r_data_o is the lane-ordered concatenation, lane 0 in LSBs.
REQ-019 Response latency SHALL be 1 cycle after the last lane response of a transaction.
REQ-020 The outstanding counter SHALL increment on gnt_o, decrement on r_valid_o, hold when both occur in one cycle; range 0..DEPTH.
REQ-021 At outstanding == DEPTH no new lane requests SHALL issue, including in a cycle in which r_valid_o asserts (no bypass).
REQ-022 A lane push into a full FIFO is a protocol error; the FIFO SHALL drop it and a simulation assertion SHALL fire.

Reset
REQ-023 On rst_i=1 FSM->IDLE, mask=0, counter=0, FIFOs emptied; gnt_o, r_valid_o, tcdm_req_o = 0; r_data_o = 0.
REQ-024 Reset mid-ISSUE SHALL abandon the partial request; the memory side SHALL be reset together, so responses to pre-reset requests do not occur.

Configuration
REQ-025 Macro REDMULE_TCDM_SPLIT_RESP_REG_EN, when defined, SHALL insert an output register on r_data_o/r_valid_o, making response latency 2 cycles; counter decrement stays on FIFO pop.
REQ-026 Without REDMULE_TCDM_SPLIT_RESP_REG_EN, r_data_o/r_valid_o SHALL be driven combinationally from FIFO heads (latency 1).

Structure
REQ-027 The FSM state enum and the lane-width/byte-offset localparam functions SHALL live in redmule_pkg.
REQ-028 The per-lane FIFO SHALL be a sub-module redmule_tcdm_lane_fifo, instantiated MP times.

Verification
REQ-029 Defaults; all tcdm_gnt_i=1, read at 0x1000 -> lane addresses 0x1000/0x1008/0x1010/0x1018, gnt_o same cycle, r_valid_o 1 cycle after all lanes respond.
REQ-030 Lane 2 grants 3 cycles late -> lanes 0,1,3 req drop after cycle 0, lane 2 held, gnt_o once in cycle 3.
REQ-031 Lane responses skewed (lane 3 two cycles late) -> single r_valid_o, data {l3,l2,l1,l0} correct.
REQ-032 DEPTH=2, responses withheld, three back-to-back requests -> third not issued until first r_valid_o.
REQ-033 rst_i=1 during ISSUE with mask=0b0011 -> next cycle all outputs 0, counter 0, new request issues to all lanes.
REQ-034 REDMULE_TCDM_SPLIT_RESP_REG_EN defined, rerun REQ-029 -> r_valid_o 2 cycles after last lane response.
